qspi_psram_responder: RTL and testbench
=======================================

QSPI_PSRAM_RESPONDER -- requirements
Module: qspi_psram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the byte capacity of the internal array.
REQ-002 SHALL have parameter READ_WAIT, default 4, meaning the number of wait cycles between the last address nibble and the first read data nibble (legal range 2..15).
REQ-003 SHALL have port clk2, input, 1, the only clock; one bus bit-time per clk2 cycle while ram_cs_n is low.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port ram_cs_n, input, 1, bus chip select, active low.
REQ-006 SHALL have port io_in, input, 4, bus data sampled from the initiator.
REQ-007 SHALL have port io_out, output, 4, registered read data nibble.
REQ-008 SHALL have port io_oe, output, 4, per-bit drive enable for io_out.
REQ-009 SHALL have port quad_mode, output, 1, high when the bus is in 4-bit mode.
REQ-010 SHALL have port err, output, 1, a one-cycle pulse flagging a protocol error.

Function
REQ-011 Sampling: SHALL sample io_in and ram_cs_n on every rising clk2 edge. Cycle 0 is the first sampled cycle with ram_cs_n low after ram_cs_n was high.
REQ-012 SPI mode (quad_mode=0) bus format:
- commands are 8 cycles, one bit per cycle on io_in[0], MSB first; io_in[3:1] are ignored.
- recognised commands: 0x66 (RESET_EN), 0x99 (RESET), 0x35 (ENTER_QUAD).
REQ-013 Quad mode bus format:
- commands are 2 nibbles, high nibble first.
- recognised commands: 0x0B (READ), 0x38 (WRITE), 0x66, 0x99, 0xF5 (EXIT_QUAD).
REQ-014 State machine: IDLE -> CMD -> {ADDR -> (WAIT -> RDATA) | WDATA} | DONE | IGNORE. ram_cs_n sampled high in any state SHALL return the FSM to IDLE on that edge.
REQ-015 ENTER_QUAD / EXIT_QUAD: quad_mode SHALL change on the edge that samples ram_cs_n high after a complete command. Any further cycles within the same CS window SHALL be ignored.
REQ-016 Reset command pairing:
- 0x99 SHALL take effect only if the immediately preceding CS window carried exactly 0x66.
- an effective 0x99 SHALL clear quad_mode and leave the array contents unchanged.
- an unpaired 0x99 SHALL raise err.
REQ-017 Address phase: 6 nibbles (cycles 2-7), MSB nibble first, forming a 24-bit byte address. Only bits [DEPTH_LOG2-1:0] are used; upper bits are ignored silently.
REQ-018 WRITE data phase (from cycle 8):
- nibble pairs form bytes, high nibble first.
- each byte is written on the cycle its low nibble is sampled.
- the address increments by one per byte and wraps modulo 2^DEPTH_LOG2.
- an odd trailing nibble at CS high SHALL be discarded.
REQ-019 READ wait phase: cycles 8 .. 7+READ_WAIT are wait cycles, with io_oe=0. The array read for the first byte SHALL be issued during this window (synchronous RAM, 1-cycle latency).
REQ-020 READ data phase:
- the first data nibble (high nibble of byte A) SHALL be valid on io_out, with io_oe=4'hF, in the clk2 period following the edge that samples cycle 7+READ_WAIT.
- one nibble is presented per cycle after that: high nibble then low nibble, address ascending with wrap.
- reads continue for as long as ram_cs_n stays low.
REQ-021 io_oe SHALL be forced to 0 combinationally whenever ram_cs_n is high, and cleared in its register on the same edge.
REQ-022 Protocol errors (err is pulsed one cycle after detection, and the FSM enters IGNORE):
- an unrecognised command, including READ/WRITE/EXIT_QUAD issued in SPI mode;
- ram_cs_n rising before a command or address completes.
REQ-023 Simultaneous events: a write to byte X and a read of byte X in the same cycle cannot occur, since a window is either read or write; no bypass is required.

Reset
REQ-024 While rst is high, the FSM SHALL be in IDLE, with quad_mode=0, io_oe=0, io_out=0, err=0, and the RESET_EN pairing flag cleared.
REQ-025 rst SHALL NOT clear the array. A rst asserted mid-transaction SHALL abort the transaction; bytes already written SHALL persist.
REQ-026 After rst is released, the responder SHALL wait for ram_cs_n high before accepting a new cycle 0.

Verification
REQ-027 SPI 0x66 window, CS high, SPI 0x99 window, CS high, SPI 0x35 window, CS high -> quad_mode=1 after the last CS high; err never pulses.
REQ-028 Quad WRITE to 0x000010 with data 0x0123456789ABCDEF, then quad READ of 16 nibbles from 0x000010 with READ_WAIT=4 -> io_out returns 0,1,2,...,F starting in the period after cycle 11; io_oe=F only during the data phase.
REQ-029 WRITE of 2 bytes 0xAA,0x55 at address 2^DEPTH_LOG2-1, then READ of 2 bytes from the same address -> the array top byte is 0xAA and byte 0 is 0x55 (wrap).
REQ-030 Quad command 0x99 not preceded by 0x66 -> err pulses once; quad_mode stays 1. Quad command 0x12 -> err pulses once, and io_oe stays 0 until the next window.
REQ-031 rst asserted at write data nibble 5 -> the first 2 bytes persist and the third byte is unchanged; quad_mode=0 after reset; a subsequent SPI 0x35 window is accepted.
REQ-032 ram_cs_n raised during a read data phase -> io_oe drops to 0 in the same cycle, and the next window starts at IDLE.

Source files
------------

// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM responder: SPI/quad command decode, 24-bit addressed byte array,
// quad read with configurable wait cycles and quad write with address wrap.
module qspi_psram_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned READ_WAIT  = 4
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       ram_cs_n,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [3:0] io_oe,
  output logic       quad_mode,
  output logic       err
);
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = 5;
  localparam logic [CW-1:0] LAST_CMD_SPI  = CW'(7);
  localparam logic [CW-1:0] LAST_CMD_QUAD = CW'(1);
  localparam logic [CW-1:0] LAST_ADDR     = CW'(7);
  localparam logic [CW-1:0] LAST_WAIT     = CW'(7 + READ_WAIT);

  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam logic [7:0] CMD_WRITE  = 8'h38;
  localparam logic [7:0] CMD_RST_EN = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;
  localparam logic [7:0] CMD_ENTER  = 8'h35;
  localparam logic [7:0] CMD_EXIT   = 8'hF5;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_DONE, S_IGNORE
  } state_t;

  // action applied when a completed command window closes
  typedef enum logic [1:0] {OP_NONE, OP_RST_EN, OP_SET_Q, OP_CLR_Q} op_t;

  state_t        state, state_d;
  op_t           op_q, cmd_op;
  logic          err_d, start, cmd_last, addr_last, wait_last, mem_we;
  logic          cs_prev, rst_en_q, is_wr, nib_sel;
  logic [CW-1:0] cnt;
  logic [6:0]    cmd_sr;
  logic [7:0]    cmd_full;
  logic [AW-1:0] addr_sr, addr_full, wr_addr, rd_addr;
  logic [3:0]    hi_hold, lo_hold, oe_q;
  logic [7:0]    rdata;
  logic [7:0]    mem [DEPTH];

  assign cmd_full  = quad_mode ? {cmd_sr[3:0], io_in} : {cmd_sr[6:0], io_in[0]};
  assign addr_full = AW'({addr_sr, io_in});
  assign cmd_last  = (state == S_CMD) &&
                     (cnt == (quad_mode ? LAST_CMD_QUAD : LAST_CMD_SPI));
  assign addr_last = (state == S_ADDR) && (cnt == LAST_ADDR);
  assign wait_last = (state == S_WAIT) && (cnt == LAST_WAIT);
  assign start     = (state == S_IDLE) && !ram_cs_n && cs_prev;
  assign mem_we    = !rst && !ram_cs_n && (state == S_WDATA) && nib_sel;
  assign io_oe     = ram_cs_n ? 4'h0 : oe_q;

  always_ff @(posedge clk2) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    cmd_op  = OP_NONE;
    if (ram_cs_n) begin
      state_d = S_IDLE;
      err_d   = (state == S_CMD) || (state == S_ADDR);
    end else begin
      case (state)
        S_IDLE:  if (cs_prev) state_d = S_CMD;
        S_CMD: begin
          if (cmd_last) begin
            state_d = S_IGNORE;
            err_d   = 1'b1;
            case (cmd_full)
              CMD_RST_EN: begin state_d = S_DONE; err_d = 1'b0; cmd_op = OP_RST_EN; end
              CMD_RST:    if (rst_en_q) begin
                            state_d = S_DONE; err_d = 1'b0; cmd_op = OP_CLR_Q;
                          end
              CMD_ENTER:  if (!quad_mode) begin
                            state_d = S_DONE; err_d = 1'b0; cmd_op = OP_SET_Q;
                          end
              CMD_EXIT:   if (quad_mode) begin
                            state_d = S_DONE; err_d = 1'b0; cmd_op = OP_CLR_Q;
                          end
              CMD_READ, CMD_WRITE: if (quad_mode) begin
                            state_d = S_ADDR; err_d = 1'b0;
                          end
              default: ;
            endcase
          end
        end
        S_ADDR:  if (addr_last) state_d = is_wr ? S_WDATA : S_WAIT;
        S_WAIT:  if (wait_last) state_d = S_RDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      cs_prev   <= 1'b0;
      quad_mode <= 1'b0;
      err       <= 1'b0;
      rst_en_q  <= 1'b0;
      oe_q      <= 4'h0;
      io_out    <= 4'h0;
      op_q      <= OP_NONE;
      cnt       <= '0;
      cmd_sr    <= '0;
      is_wr     <= 1'b0;
      addr_sr   <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      nib_sel   <= 1'b0;
      hi_hold   <= 4'h0;
      lo_hold   <= 4'h0;
    end else begin
      cs_prev <= ram_cs_n;
      err     <= err_d;
      cnt     <= start ? CW'(1) : cnt + CW'(1);
      if (ram_cs_n) begin
        oe_q <= 4'h0;
        // window close: commit mode changes and the RESET_EN pairing flag
        if (state != S_IDLE) begin
          rst_en_q <= (state == S_DONE) && (op_q == OP_RST_EN);
          if ((state == S_DONE) && (op_q == OP_SET_Q)) quad_mode <= 1'b1;
          if ((state == S_DONE) && (op_q == OP_CLR_Q)) quad_mode <= 1'b0;
        end
      end else begin
        if (start || (state == S_CMD))
          cmd_sr <= quad_mode ? {cmd_sr[2:0], io_in} : {cmd_sr[5:0], io_in[0]};
        if (start) op_q <= OP_NONE;
        if (cmd_last) begin
          op_q  <= cmd_op;
          is_wr <= (cmd_full == CMD_WRITE);
        end
        // trailing cycles after 0x66 mean the window was not exactly RESET_EN
        if ((state == S_DONE) && (op_q == OP_RST_EN)) op_q <= OP_NONE;
        if (state == S_ADDR) addr_sr <= addr_full;
        if (addr_last) begin
          wr_addr <= addr_full;
          rd_addr <= addr_full;
          nib_sel <= 1'b0;
        end
        if (wait_last || ((state == S_RDATA) && !nib_sel)) begin
          io_out  <= rdata[7:4];
          lo_hold <= rdata[3:0];
          rd_addr <= rd_addr + AW'(1);
          nib_sel <= 1'b1;
          oe_q    <= 4'hF;
        end else if (state == S_RDATA) begin
          io_out  <= lo_hold;
          nib_sel <= 1'b0;
        end
        if (state == S_WDATA) begin
          nib_sel <= !nib_sel;
          if (!nib_sel) hi_hold <= io_in;
          else          wr_addr <= wr_addr + AW'(1);
        end
      end
    end
  end

  // byte array: synchronous read every cycle, never reset
  always_ff @(posedge clk2) begin
    if (mem_we) mem[wr_addr] <= {hi_hold, io_in};
    rdata <= mem[rd_addr];
  end
endmodule

// File: tb/tb_qspi_psram_responder.sv
// Directed bench for qspi_psram_responder: mode switching, reset pairing,
// quad write/read with wrap, protocol errors and mid-transaction rst.
module tb_qspi_psram_responder;
  localparam int unsigned DEPTH_LOG2 = 12;
  localparam int unsigned READ_WAIT  = 4;

  logic       clk2 = 1'b0;
  logic       rst;
  logic       ram_cs_n;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic       quad_mode;
  logic       err;

  int checks  = 0;
  int errors  = 0;
  int err_cnt = 0;
  int base;

  always #5 clk2 = ~clk2;

  qspi_psram_responder #(.DEPTH_LOG2(DEPTH_LOG2), .READ_WAIT(READ_WAIT)) dut (
    .clk2(clk2), .rst(rst), .ram_cs_n(ram_cs_n), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .quad_mode(quad_mode), .err(err)
  );

  always @(negedge clk2) if (err === 1'b1) err_cnt++;

  initial begin
    #300000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // one bus cycle: drive on negedge, return just after the sampling posedge
  task automatic bus(input logic cs, input logic [3:0] d);
    @(negedge clk2);
    ram_cs_n = cs;
    io_in    = d;
    @(posedge clk2);
    #1;
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bus(1'b0, {3'b000, b[i]});
  endtask

  task automatic quad_cmd(input logic [7:0] b);
    bus(1'b0, b[7:4]);
    bus(1'b0, b[3:0]);
  endtask

  task automatic quad_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) bus(1'b0, a[4*i +: 4]);
  endtask

  task automatic quad_write(input logic [23:0] a, input logic [63:0] nibs, input int n);
    quad_cmd(8'h38);
    quad_addr(a);
    for (int i = 0; i < n; i++) bus(1'b0, nibs[4*(n-1-i) +: 4]);
    bus(1'b1, 4'h0);
  endtask

  task automatic quad_read_check(input logic [23:0] a, input logic [63:0] nibs,
                                 input int n, input string tag);
    quad_cmd(8'h0B);
    quad_addr(a);
    for (int w = 0; w < int'(READ_WAIT) - 1; w++) begin
      bus(1'b0, 4'h0);
      check({tag, "_wait_oe"}, 32'(io_oe), 32'h0);
    end
    for (int i = 0; i < n; i++) begin
      bus(1'b0, 4'h0);
      check({tag, "_data"}, 32'({io_oe, io_out}), 32'({4'hF, nibs[4*(n-1-i) +: 4]}));
    end
    @(negedge clk2);
    ram_cs_n = 1'b1;
    #1;
    check({tag, "_oe_drop"}, 32'(io_oe), 32'h0);
    @(posedge clk2);
    #1;
    check({tag, "_oe_reg"}, 32'(io_oe), 32'h0);
  endtask

  initial begin
    rst      = 1'b1;
    ram_cs_n = 1'b1;
    io_in    = 4'h0;
    repeat (3) @(posedge clk2);
    #1;
    check("rst_quad", 32'(quad_mode), 32'h0);
    check("rst_oe",   32'(io_oe),     32'h0);
    check("rst_out",  32'(io_out),    32'h0);
    check("rst_err",  32'(err),       32'h0);
    @(negedge clk2);
    rst = 1'b0;
    bus(1'b1, 4'h0);

    // SPI RESET_EN, RESET, ENTER_QUAD
    base = err_cnt;
    spi_cmd(8'h66); bus(1'b1, 4'h0);
    spi_cmd(8'h99); bus(1'b1, 4'h0);
    check("spi_rst_quad", 32'(quad_mode), 32'h0);
    spi_cmd(8'h35);
    check("enter_before_cs", 32'(quad_mode), 32'h0);
    bus(1'b1, 4'h0);
    check("enter_quad", 32'(quad_mode), 32'h1);
    check("seq_no_err", 32'(err_cnt - base), 32'h0);

    // write 8 bytes then read 16 nibbles back
    quad_write(24'h000010, 64'h0123456789ABCDEF, 16);
    quad_read_check(24'h000010, 64'h0123456789ABCDEF, 16, "rd16");

    // address wrap at the top of the array, upper address bits ignored
    quad_write(24'h000FFF, 64'hAA55, 4);
    quad_read_check(24'h000FFF, 64'hAA55, 4, "wrap");
    quad_read_check(24'h000000, 64'h55, 2, "byte0");
    quad_read_check(24'h123FFF, 64'hAA, 2, "upper_ign");

    // odd trailing nibble discarded, next byte untouched
    quad_write(24'h000014, 64'h987, 3);
    quad_read_check(24'h000014, 64'h98AB, 4, "odd_nib");

    // unpaired RESET and unknown command
    base = err_cnt;
    quad_cmd(8'h99);
    check("unpaired_err", 32'(err), 32'h1);
    bus(1'b0, 4'h0);
    check("err_one_cycle", 32'(err), 32'h0);
    bus(1'b1, 4'h0);
    check("unpaired_quad", 32'(quad_mode), 32'h1);
    quad_cmd(8'h12);
    check("bad_cmd_err", 32'(err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      bus(1'b0, 4'hF);
      check("bad_cmd_oe", 32'(io_oe), 32'h0);
    end
    bus(1'b1, 4'h0);
    check("err_pulses", 32'(err_cnt - base), 32'h2);

    // CS rising inside the address phase
    quad_cmd(8'h0B);
    bus(1'b0, 4'h0);
    bus(1'b0, 4'h0);
    bus(1'b1, 4'h0);
    check("addr_abort_err", 32'(err), 32'h1);

    // EXIT_QUAD, then READ in SPI mode is an error
    quad_cmd(8'hF5);
    check("exit_before_cs", 32'(quad_mode), 32'h1);
    bus(1'b1, 4'h0);
    check("exit_quad", 32'(quad_mode), 32'h0);
    spi_cmd(8'h0B);
    check("spi_read_err", 32'(err), 32'h1);
    bus(1'b1, 4'h0);

    // paired reset in quad mode clears quad_mode without error
    spi_cmd(8'h35); bus(1'b1, 4'h0);
    check("reenter_quad", 32'(quad_mode), 32'h1);
    quad_cmd(8'h66); bus(1'b1, 4'h0);
    quad_cmd(8'h99);
    check("paired_no_err", 32'(err), 32'h0);
    bus(1'b1, 4'h0);
    check("paired_clr_quad", 32'(quad_mode), 32'h0);
    spi_cmd(8'h35); bus(1'b1, 4'h0);

    // rst at write data nibble 5
    quad_write(24'h000030, 64'hC0C1C2, 6);
    quad_cmd(8'h38);
    quad_addr(24'h000030);
    for (int i = 0; i < 5; i++) bus(1'b0, 4'(20'h11223 >> (4 * (4 - i))));
    @(negedge clk2);
    rst   = 1'b1;
    io_in = 4'h3;
    @(posedge clk2);
    #1;
    check("mid_rst_quad", 32'(quad_mode), 32'h0);
    check("mid_rst_oe",   32'(io_oe),     32'h0);
    @(negedge clk2);
    @(negedge clk2);
    rst = 1'b0;
    spi_cmd(8'h35);
    bus(1'b1, 4'h0);
    check("no_start_after_rst", 32'(quad_mode), 32'h0);
    spi_cmd(8'h35);
    bus(1'b1, 4'h0);
    check("enter_after_rst", 32'(quad_mode), 32'h1);
    quad_read_check(24'h000030, 64'h1122C2, 6, "rst_persist");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
